// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - ASCII "w ADDR DATA<CR>" / "r ADDR<CR>" command parser
//
// Purpose: turns a stream of received UART bytes into single request/acknowledge
// register-bus transactions. Hex digits are accepted in either case. A malformed
// line is flagged once and then discarded up to the next CR.
//
// Ports:
//   iCLK       system clock
//   iRESETn    asynchronous active-low reset
//   iRX_VALID  one-cycle strobe, iRX_DATA holds a received byte
//   iRX_DATA   received byte
//   oREQ       request level, held until iACK is sampled
//   oREQ_WR    1 = write, 0 = read
//   oADDR      parsed address, zero-extended
//   oWDATA     parsed write data, zero-extended (0 for reads)
//   iACK       bus master accepted the request
//   oERR       one-cycle pulse on entry into the error state
//   oOVERRUN   one-cycle pulse when a byte is dropped while a request is pending
//   oBUSY      high whenever the parser is not idle

module uart_cmd_parser #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              iCLK,
  input  logic              iRESETn,
  input  logic              iRX_VALID,
  input  logic [7:0]        iRX_DATA,
  output logic              oREQ,
  output logic              oREQ_WR,
  output logic [ADDR_W-1:0] oADDR,
  output logic [DATA_W-1:0] oWDATA,
  input  logic              iACK,
  output logic              oERR,
  output logic              oOVERRUN,
  output logic              oBUSY
);

  localparam int ADDR_DIGITS = ADDR_W / 4;
  localparam int DATA_DIGITS = DATA_W / 4;
  localparam int MAX_DIGITS  = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
  // One spare bit so the counter can hold MAX_DIGITS itself.
  localparam int CNT_W       = $clog2(MAX_DIGITS + 1) + 1;

  localparam logic [7:0] CH_W  = 8'h77;
  localparam logic [7:0] CH_R  = 8'h72;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SP0,
    S_ADDR,
    S_DATA,
    S_ISSUE,
    S_ERROR
  } state_e;

  state_e             state_q, state_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               ovr_q, ovr_d;
  logic               is_hex;
  logic [3:0]         nib;

  // Returns {valid, nibble}. Letters 'A'-'F' and 'a'-'f' share low nibbles 1-6.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    hex_decode = 5'd0;
    if (b >= 8'h30 && b <= 8'h39) begin
      hex_decode = {1'b1, b[3:0]};
    end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
      hex_decode = {1'b1, b[3:0] + 4'd9};
    end
  endfunction

  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    ovr_d         = 1'b0;
    {is_hex, nib} = hex_decode(iRX_DATA);

    if (state_q == S_ISSUE) begin
      // A byte coincident with the acknowledge is still an ISSUE-state byte.
      if (iACK) state_d = S_IDLE;
      if (iRX_VALID) ovr_d = 1'b1;
    end else if (iRX_VALID) begin
      case (state_q)
        S_IDLE: begin
          if (iRX_DATA == CH_W || iRX_DATA == CH_R) begin
            state_d = S_SP0;
            wr_d    = (iRX_DATA == CH_W);
            addr_d  = '0;
            data_d  = '0;
            cnt_d   = '0;
          end else if (iRX_DATA != CH_CR && iRX_DATA != CH_LF) begin
            state_d = S_ERROR;
          end
        end
        S_SP0: begin
          state_d = (iRX_DATA == CH_SP) ? S_ADDR : S_ERROR;
        end
        S_ADDR: begin
          if (is_hex) begin
            if (cnt_q == CNT_W'(ADDR_DIGITS)) begin
              state_d = S_ERROR;
            end else begin
              addr_d = (addr_q << 4) | ADDR_W'(nib);
              cnt_d  = cnt_q + 1'b1;
            end
          end else if (iRX_DATA == CH_SP && cnt_q != '0 && wr_q) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end else if (iRX_DATA == CH_CR && cnt_q != '0 && !wr_q) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_ERROR;
          end
        end
        S_DATA: begin
          if (is_hex) begin
            if (cnt_q == CNT_W'(DATA_DIGITS)) begin
              state_d = S_ERROR;
            end else begin
              data_d = (data_q << 4) | DATA_W'(nib);
              cnt_d  = cnt_q + 1'b1;
            end
          end else if (iRX_DATA == CH_CR && cnt_q != '0) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_ERROR;
          end
        end
        S_ERROR: begin
          if (iRX_DATA == CH_CR) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Flag only the entry into ERROR, not bytes dropped while already there.
    err_d = (state_d == S_ERROR) && (state_q != S_ERROR);
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign oREQ     = (state_q == S_ISSUE);
  assign oREQ_WR  = wr_q;
  assign oADDR    = addr_q;
  assign oWDATA   = data_q;
  assign oERR     = err_q;
  assign oOVERRUN = ovr_q;
  assign oBUSY    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed self-checking bench for uart_cmd_parser

module tb_uart_cmd_parser;

  logic        clk;
  logic        rst_n;
  logic        rx_valid, rx2_valid;
  logic [7:0]  rx_data, rx2_data;
  logic        ack, ack2;

  logic        req, req_wr, err, ovr, busy;
  logic [15:0] addr;
  logic [31:0] wdata;

  logic        req2, req_wr2, err2, ovr2, busy2;
  logic [7:0]  addr2;
  logic [7:0]  wdata2;

  int n_vec;
  int n_miss;
  int err_cnt;
  int ovr_cnt;
  logic last_err;
  logic last_ovr;

  uart_cmd_parser dut (
    .iCLK      (clk),
    .iRESETn   (rst_n),
    .iRX_VALID (rx_valid),
    .iRX_DATA  (rx_data),
    .oREQ      (req),
    .oREQ_WR   (req_wr),
    .oADDR     (addr),
    .oWDATA    (wdata),
    .iACK      (ack),
    .oERR      (err),
    .oOVERRUN  (ovr),
    .oBUSY     (busy)
  );

  uart_cmd_parser #(.ADDR_W(8), .DATA_W(8)) dut8 (
    .iCLK      (clk),
    .iRESETn   (rst_n),
    .iRX_VALID (rx2_valid),
    .iRX_DATA  (rx2_data),
    .oREQ      (req2),
    .oREQ_WR   (req_wr2),
    .oADDR     (addr2),
    .oWDATA    (wdata2),
    .iACK      (ack2),
    .oERR      (err2),
    .oOVERRUN  (ovr2),
    .oBUSY     (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one byte at a negedge; return at the next negedge after it was consumed.
  task automatic put(input logic [7:0] b, input bit which);
    if (which) begin
      rx2_valid = 1'b1;
      rx2_data  = b;
    end else begin
      rx_valid = 1'b1;
      rx_data  = b;
    end
    @(negedge clk);
    last_err = which ? err2 : err;
    last_ovr = which ? ovr2 : ovr;
    if (last_err) err_cnt++;
    if (last_ovr) ovr_cnt++;
  endtask

  task automatic idle_rx();
    rx_valid  = 1'b0;
    rx2_valid = 1'b0;
  endtask

  task automatic send(input string s, input bit which);
    for (int i = 0; i < s.len(); i++) put(s[i], which);
    idle_rx();
  endtask

  task automatic line(input string s, input bit which);
    for (int i = 0; i < s.len(); i++) put(s[i], which);
    put(8'h0D, which);
    idle_rx();
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_miss = 0; err_cnt = 0; ovr_cnt = 0;
    last_err = 1'b0; last_ovr = 1'b0;
    rst_n = 1'b0; ack = 1'b0; ack2 = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00; rx2_valid = 1'b0; rx2_data = 8'h00;
    repeat (3) @(negedge clk);

    check_eq("reset_req",   {63'd0, req},    64'd0);
    check_eq("reset_wr",    {63'd0, req_wr}, 64'd0);
    check_eq("reset_addr",  {48'd0, addr},   64'd0);
    check_eq("reset_wdata", {32'd0, wdata},  64'd0);
    check_eq("reset_err",   {63'd0, err},    64'd0);
    check_eq("reset_ovr",   {63'd0, ovr},    64'd0);
    check_eq("reset_busy",  {63'd0, busy},   64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full write, mixed-case data
    err_cnt = 0;
    line("w 12AB DEADbeef", 0);
    check_eq("wr_req",   {63'd0, req},    64'd1);
    check_eq("wr_wr",    {63'd0, req_wr}, 64'd1);
    check_eq("wr_addr",  {48'd0, addr},   64'h12AB);
    check_eq("wr_wdata", {32'd0, wdata},  64'hDEADBEEF);
    check_eq("wr_noerr", 64'(err_cnt),    64'd0);
    do_ack();
    check_eq("wr_req_drop", {63'd0, req},  64'd0);
    check_eq("wr_idle",     {63'd0, busy}, 64'd0);

    // Short read held for 5 cycles without ack
    line("r 7", 0);
    check_eq("rd_wr",    {63'd0, req_wr}, 64'd0);
    check_eq("rd_addr",  {48'd0, addr},   64'h7);
    check_eq("rd_wdata", {32'd0, wdata},  64'd0);
    for (int i = 0; i < 5; i++) begin
      check_eq("rd_req_hold", {63'd0, req}, 64'd1);
      @(negedge clk);
    end
    do_ack();
    check_eq("rd_req_drop",  {63'd0, req},  64'd0);
    check_eq("rd_addr_held", {48'd0, addr}, 64'h7);

    // Address overflow on the fifth digit
    err_cnt = 0;
    send("r 1234", 0);
    check_eq("ovf_before", 64'(err_cnt), 64'd0);
    put("5", 0);
    check_eq("ovf_err_on_5", {63'd0, last_err}, 64'd1);
    line("", 0);
    check_eq("ovf_err_once", 64'(err_cnt),  64'd1);
    check_eq("ovf_no_req",   {63'd0, req},  64'd0);
    check_eq("ovf_idle",     {63'd0, busy}, 64'd0);
    line("r 1", 0);
    check_eq("ovf_next_req",  {63'd0, req},  64'd1);
    check_eq("ovf_next_addr", {48'd0, addr}, 64'h1);
    do_ack();

    // Missing data: the CR itself is the offending byte, so a second CR recovers
    err_cnt = 0;
    line("w 10", 0);
    check_eq("nodata_err",  64'(err_cnt),  64'd1);
    check_eq("nodata_busy", {63'd0, busy}, 64'd1);
    line("", 0);
    check_eq("nodata_recover", {63'd0, busy}, 64'd0);

    // Unknown command, followed by more junk: only one error pulse
    err_cnt = 0;
    line("xyz", 0);
    check_eq("badcmd_err",  64'(err_cnt),  64'd1);
    check_eq("badcmd_idle", {63'd0, busy}, 64'd0);

    // Blank CRLF line
    err_cnt = 0;
    put(8'h0D, 0);
    put(8'h0A, 0);
    idle_rx();
    check_eq("crlf_noerr", 64'(err_cnt),  64'd0);
    check_eq("crlf_noreq", {63'd0, req},  64'd0);
    check_eq("crlf_idle",  {63'd0, busy}, 64'd0);

    // Overrun while request pending
    ovr_cnt = 0;
    line("r 1", 0);
    put(8'h41, 0);
    idle_rx();
    check_eq("ovr_pulse", {63'd0, last_ovr}, 64'd1);
    @(negedge clk);
    check_eq("ovr_one_cycle", {63'd0, ovr},  64'd0);
    check_eq("ovr_req_kept",  {63'd0, req},  64'd1);
    check_eq("ovr_addr_kept", {48'd0, addr}, 64'h1);
    do_ack();
    check_eq("ovr_idle", {63'd0, busy}, 64'd0);

    // Byte coincident with ack is still an overrun; request ends
    line("r 3", 0);
    ack = 1'b1;
    put(8'h72, 0);
    idle_rx();
    ack = 1'b0;
    check_eq("ackbyte_ovr",  {63'd0, last_ovr}, 64'd1);
    check_eq("ackbyte_req",  {63'd0, req},      64'd0);
    check_eq("ackbyte_idle", {63'd0, busy},     64'd0);

    // Ack with no request pending is ignored
    ack = 1'b1;
    line("r 4", 0);
    check_eq("ackhigh_min_req", {63'd0, req}, 64'd1);
    @(negedge clk);
    ack = 1'b0;
    check_eq("ackhigh_drop", {63'd0, req}, 64'd0);

    // Async reset mid-line
    send("w 12", 0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", {63'd0, busy},   64'd0);
    check_eq("rst_mid_addr", {48'd0, addr},   64'd0);
    check_eq("rst_mid_wr",   {63'd0, req_wr}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    line("r 2", 0);
    check_eq("rst_after_req",  {63'd0, req},  64'd1);
    check_eq("rst_after_addr", {48'd0, addr}, 64'h2);
    do_ack();

    // 8-bit address/data instance
    err_cnt = 0;
    line("w FF 5a", 1);
    check_eq("p8_req",   {63'd0, req2},    64'd1);
    check_eq("p8_wr",    {63'd0, req_wr2}, 64'd1);
    check_eq("p8_addr",  {56'd0, addr2},   64'hFF);
    check_eq("p8_wdata", {56'd0, wdata2},  64'h5A);
    ack2 = 1'b1;
    @(negedge clk);
    ack2 = 1'b0;
    check_eq("p8_drop", {63'd0, req2}, 64'd0);
    line("w 1FF", 1);
    check_eq("p8_addr_ovf", 64'(err_cnt), 64'd1);
    err_cnt = 0;
    line("w 1 5a3", 1);
    check_eq("p8_data_ovf", 64'(err_cnt), 64'd1);
    check_eq("p8_no_req",   {63'd0, req2}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
